// File: rtl/iod_read_train_ctrl.sv
// iod_read_train_ctrl: per-lane DDR3 read-training sequencer; sweeps the RX delay line and parks it at the widest eye's centre.
// Ports:
//   FAB_CLK, ARST_N                 clock, asynchronous active-low reset
//   START, ABORT                    begin training (pulse), terminate training (level)
//   EYE_MONITOR_EARLY/LATE          eye-monitor flags from the IOD
//   DELAY_LINE_OUT_OF_RANGE         delay-line limit indicator, looked at in EVAL only
//   DELAY_LINE_LOAD/MOVE/DIRECTION  delay-line controls (LOAD restores tap 0)
//   EYE_MONITOR_CLEAR_FLAGS         eye-monitor flag clear pulse
//   BUSY, DONE, ERROR               status (DONE/ERROR sticky until the next LOAD)
//   TAP, EYE_START, EYE_WIDTH       current tap, chosen window start and width
module iod_read_train_ctrl #(
    parameter int TAP_MAX       = 127,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 8,
    parameter int MIN_EYE       = 4
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       START,
    input  logic       ABORT,
    input  logic       EYE_MONITOR_EARLY,
    input  logic       EYE_MONITOR_LATE,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic [7:0] TAP,
    output logic [7:0] EYE_START,
    output logic [7:0] EYE_WIDTH
);
    localparam logic [7:0]  TAP_LAST = TAP_MAX[7:0];
    localparam logic [7:0]  MIN_W    = MIN_EYE[7:0];
    localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] SMP_LAST = 16'(SAMPLE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP,
        S_FINISH, S_RET_MV, S_RET_GAP, S_DONE, S_RELOAD
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fail_q, fail_d;
    logic [7:0]  tap_q, tap_d, run_len_q, run_len_d, run_start_q, run_start_d;
    logic [7:0]  best_len_q, best_len_d, best_start_q, best_start_d, centre_q, centre_d;
    logic [7:0]  eye_start_q, eye_start_d, eye_width_q, eye_width_d;
    logic        load_q, load_d, move_q, move_d, dir_q, dir_d, clr_q, clr_d;
    logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic        fail_now, close_run, fin_ok;
    logic [7:0]  fin_len, fin_start, fin_centre;

    // A run still open at the end of the sweep competes with the best closed run.
    assign fail_now   = fail_q | DELAY_LINE_OUT_OF_RANGE;
    assign fin_len    = (run_len_q > best_len_q) ? run_len_q : best_len_q;
    assign fin_start  = (run_len_q > best_len_q) ? run_start_q : best_start_q;
    assign fin_centre = fin_start + (fin_len >> 1);

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fail_q       <= 1'b0;
            tap_q        <= '0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            centre_q     <= '0;
            eye_start_q  <= '0;
            eye_width_q  <= '0;
            load_q       <= 1'b0;
            move_q       <= 1'b0;
            dir_q        <= 1'b0;
            clr_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fail_q       <= fail_d;
            tap_q        <= tap_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            centre_q     <= centre_d;
            eye_start_q  <= eye_start_d;
            eye_width_q  <= eye_width_d;
            load_q       <= load_d;
            move_q       <= move_d;
            dir_q        <= dir_d;
            clr_q        <= clr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = (START && !ABORT) ? S_LOAD : S_IDLE;
            S_LOAD:    state_d = S_CLEAR;
            S_CLEAR:   state_d = S_SETTLE;
            S_SETTLE:  state_d = (cnt_q == SET_LAST) ? S_SAMPLE : S_SETTLE;
            S_SAMPLE:  state_d = (cnt_q == SMP_LAST) ? S_EVAL : S_SAMPLE;
            S_EVAL:    state_d = (tap_q == TAP_LAST || DELAY_LINE_OUT_OF_RANGE) ? S_FINISH : S_STEP;
            S_STEP:    state_d = S_CLEAR;
            S_FINISH:  state_d = (fin_len < MIN_W) ? S_RELOAD : (tap_q == fin_centre) ? S_DONE : S_RET_MV;
            S_RET_MV:  state_d = S_RET_GAP;
            S_RET_GAP: state_d = (tap_q == centre_q) ? S_DONE : S_RET_MV;
            default:   state_d = S_IDLE;
        endcase
        // RELOAD is excluded so a held ABORT yields a single restoring LOAD pulse.
        if (ABORT && state_q != S_IDLE && state_q != S_RELOAD) state_d = S_RELOAD;
    end

    always_comb begin
        cnt_d        = (state_d == state_q && (state_q == S_SETTLE || state_q == S_SAMPLE)) ? cnt_q + 16'd1 : '0;
        fail_d       = (state_q == S_CLEAR) ? 1'b0 :
                       (state_q == S_SAMPLE) ? (fail_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE) : fail_q;
        tap_d        = (state_d == S_LOAD || state_d == S_RELOAD) ? 8'd0 :
                       (state_q == S_STEP) ? tap_q + 8'd1 :
                       (state_q == S_RET_MV) ? tap_q - 8'd1 : tap_q;
        close_run    = state_q == S_EVAL && fail_now && run_len_q > best_len_q;
        run_len_d    = (state_d == S_LOAD) ? 8'd0 :
                       (state_q == S_EVAL) ? (fail_now ? 8'd0 : run_len_q + 8'd1) : run_len_q;
        run_start_d  = (state_q == S_EVAL && !fail_now && run_len_q == 8'd0) ? tap_q : run_start_q;
        best_len_d   = (state_d == S_LOAD) ? 8'd0 : close_run ? run_len_q : best_len_q;
        best_start_d = (state_d == S_LOAD) ? 8'd0 : close_run ? run_start_q : best_start_q;
        centre_d     = (state_q == S_FINISH) ? fin_centre : centre_q;
        fin_ok       = state_q == S_FINISH && !ABORT;
        eye_start_d  = (fin_ok && fin_len >= MIN_W) ? fin_start : eye_start_q;
        eye_width_d  = fin_ok ? fin_len : eye_width_q;
        error_d      = (state_d == S_LOAD) ? 1'b0 : (fin_ok && fin_len < MIN_W) ? 1'b1 : error_q;
        done_d       = (state_d == S_LOAD) ? 1'b0 : (state_d == S_DONE) ? 1'b1 : done_q;
        busy_d       = !(state_d inside {S_IDLE, S_DONE, S_RELOAD});
        load_d       = state_d == S_LOAD || state_d == S_RELOAD;
        move_d       = state_d == S_STEP || state_d == S_RET_MV;
        dir_d        = state_d == S_STEP;
        clr_d        = state_d == S_CLEAR;
    end

    assign DELAY_LINE_LOAD         = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign BUSY                    = busy_q;
    assign DONE                    = done_q;
    assign ERROR                   = error_q;
    assign TAP                     = tap_q;
    assign EYE_START               = eye_start_q;
    assign EYE_WIDTH               = eye_width_q;
endmodule

// File: tb/tb_iod_read_train_ctrl.sv
// tb_iod_read_train_ctrl: directed training scenarios checked against a cycle-schedule model and hand-computed results.
module tb_iod_read_train_ctrl;
    localparam int S = 4;
    localparam int M = 8;
    localparam int P = 1 + S + M + 1 + 1;
    localparam int TMAX = 127;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N, START, ABORT;
    logic       EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE;
    logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
    logic       BUSY, DONE, ERROR;
    logic [7:0] TAP, EYE_START, EYE_WIDTH;

    iod_read_train_ctrl dut (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .START(START), .ABORT(ABORT),
        .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY), .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .TAP(TAP), .EYE_START(EYE_START), .EYE_WIDTH(EYE_WIDTH)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_chk = 0, n_pass = 0;
    // Lane model: delay-line position follows the DUT's pulses; flags come from the pass mask.
    logic [255:0] pass_mask = '0;
    int pos = 0, oor_tap = 999;
    int n_clr = 0, n_inc = 0, n_dec = 0, n_load = 0;
    // Expected-schedule parameters for the current run.
    int exp_n, exp_ok, exp_start, exp_width, exp_centre, abort_t;
    int t = 0;
    logic trk = 1'b0;

    assign EYE_MONITOR_EARLY       = !pass_mask[pos[7:0]] && pos < 64;
    assign EYE_MONITOR_LATE        = !pass_mask[pos[7:0]] && pos >= 64;
    assign DELAY_LINE_OUT_OF_RANGE = pos >= oor_tap;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d, time %0t)", nm, act, exp, t, $time);
    endtask

    function automatic logic [255:0] win(input int lo, input int hi);
        logic [255:0] m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    // Sweep outcome from the rules: longest strictly-longer passing run, stop at the limit tap.
    task automatic compute(input logic [255:0] mask, input int oor);
        int best = 0, bs = 0, run = 0, rs = 0;
        exp_n = 0;
        for (int k = 0; k <= TMAX; k++) begin
            exp_n = k + 1;
            if (mask[k] && k < oor) begin
                if (run == 0) rs = k;
                run++;
            end else begin
                if (run > best) begin best = run; bs = rs; end
                run = 0;
            end
            if (k >= oor) break;
        end
        if (run > best) begin best = run; bs = rs; end
        exp_ok = best >= 4;
        exp_width = best;
        exp_start = bs;
        exp_centre = bs + best / 2;
    endtask

    // Expected {LOAD,MOVE,DIR,CLEAR,BUSY,DONE,ERROR,TAP} at t cycles after the START cycle.
    function automatic logic [14:0] exp_vec(input int tc);
        logic ld = 0, mv = 0, dr = 0, cl = 0, bz = 0, dn = 0, er = 0;
        int tp = 0, r, f, d;
        f = 2 + P * (exp_n - 1) + S + M + 2;
        if (abort_t > 0 && tc > abort_t) ld = (tc == abort_t + 1);
        else if (tc == 1) begin ld = 1; bz = 1; end
        else if (tc < f) begin
            r = (tc - 2) % P; tp = (tc - 2) / P; bz = 1;
            cl = (r == 0); mv = (r == P - 1); dr = mv;
        end else if (tc == f) begin bz = 1; tp = exp_n - 1; end
        else if (exp_ok == 0) begin ld = (tc == f + 1); er = 1; end
        else begin
            d = exp_n - 1 - exp_centre; r = tc - f - 1;
            if (r < 2 * d) begin bz = 1; mv = (r % 2 == 0); tp = exp_n - 1 - (r + 1) / 2; end
            else begin dn = 1; tp = exp_centre; end
        end
        return {ld, mv, dr, cl, bz, dn, er, tp[7:0]};
    endfunction

    always @(negedge FAB_CLK) begin
        if (DELAY_LINE_LOAD) begin pos = 0; n_load++; end
        if (DELAY_LINE_MOVE && DELAY_LINE_DIRECTION) begin pos++; n_inc++; end
        if (DELAY_LINE_MOVE && !DELAY_LINE_DIRECTION) begin pos--; n_dec++; end
        if (EYE_MONITOR_CLEAR_FLAGS) n_clr++;
        if (START) t = 0; else t = t + 1;
        if (trk && t >= 1)
            chk("cycle", int'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, ERROR, TAP}), int'(exp_vec(t)));
    end

    int c_clr, c_inc, c_dec, c_load;

    task automatic run(input logic [255:0] mask, input int oor, input int ab);
        c_clr = n_clr; c_inc = n_inc; c_dec = n_dec; c_load = n_load;
        @(posedge FAB_CLK); #1;
        pass_mask = mask; oor_tap = oor; abort_t = ab;
        compute(mask, oor);
        START = 1'b1; trk = 1'b1;
        @(posedge FAB_CLK); #1;
        START = 1'b0;
        if (ab > 0) begin
            repeat (ab - 1) @(posedge FAB_CLK);
            #1 ABORT = 1'b1;
            @(posedge FAB_CLK);
            #1 ABORT = 1'b0;
        end
        for (int i = 0; i < 4000 && BUSY; i++) begin @(posedge FAB_CLK); #1; end
        chk("busy_timeout", int'(BUSY), 0);
        repeat (4) @(posedge FAB_CLK);
        #1;
    endtask

    logic [255:0] m;

    initial begin
        ARST_N = 1'b0; START = 1'b0; ABORT = 1'b0;
        #23;
        chk("reset_outputs", int'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
            EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, ERROR, TAP, EYE_START, EYE_WIDTH}), 0);
        ARST_N = 1'b1;
        repeat (3) @(posedge FAB_CLK);

        // Eye 20..59.
        run(win(20, 59), 999, 0);
        chk("t1_eye_start", EYE_START, 20);
        chk("t1_eye_width", EYE_WIDTH, 40);
        chk("t1_tap", TAP, 40);
        chk("t1_done", DONE, 1);
        chk("t1_error", ERROR, 0);
        chk("t1_clears", n_clr - c_clr, 128);
        chk("t1_inc_moves", n_inc - c_inc, 127);
        chk("t1_dec_moves", n_dec - c_dec, 87);
        chk("t1_model_start", exp_start, 20);
        chk("t1_model_centre", exp_centre, 40);

        // Never passes.
        run('0, 999, 0);
        chk("t2_error", ERROR, 1);
        chk("t2_eye_width", EYE_WIDTH, 0);
        chk("t2_tap", TAP, 0);
        chk("t2_done", DONE, 0);
        chk("t2_loads", n_load - c_load, 2);

        // Two equal windows: earliest wins.
        m = win(10, 19) | win(40, 49);
        run(m, 999, 0);
        chk("t3_eye_start", EYE_START, 10);
        chk("t3_eye_width", EYE_WIDTH, 10);
        chk("t3_tap", TAP, 15);
        chk("t3_done", DONE, 1);

        // Window open at sweep end.
        run(win(100, 127), 999, 0);
        chk("t4_eye_start", EYE_START, 100);
        chk("t4_eye_width", EYE_WIDTH, 28);
        chk("t4_tap", TAP, 114);

        // Delay-line limit at tap 64.
        run(win(30, 63), 64, 0);
        chk("t5_eye_start", EYE_START, 30);
        chk("t5_eye_width", EYE_WIDTH, 34);
        chk("t5_tap", TAP, 47);
        chk("t5_done", DONE, 1);
        chk("t5_clears", n_clr - c_clr, 65);
        chk("t5_model_n", exp_n, 65);

        // ABORT during tap 50's sampling window.
        run(win(20, 59), 999, 2 + P * 50 + S + 3);
        chk("ab_tap", TAP, 0);
        chk("ab_busy", BUSY, 0);
        chk("ab_done", DONE, 0);
        chk("ab_error", ERROR, 0);
        chk("ab_loads", n_load - c_load, 2);

        // Asynchronous reset mid-SAMPLE.
        @(posedge FAB_CLK); #1;
        trk = 1'b0; pass_mask = win(20, 59); oor_tap = 999; START = 1'b1;
        @(posedge FAB_CLK); #1;
        START = 1'b0;
        repeat (98) @(posedge FAB_CLK);
        #1;
        chk("rst_busy_before", BUSY, 1);
        ARST_N = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
            EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, ERROR, TAP, EYE_START, EYE_WIDTH}), 0);
        c_clr = n_clr; c_inc = n_inc; c_dec = n_dec; c_load = n_load;
        @(posedge FAB_CLK); #1;
        ARST_N = 1'b1;
        repeat (40) @(posedge FAB_CLK);
        #1;
        chk("rst_no_pulses", (n_clr - c_clr) + (n_inc - c_inc) + (n_dec - c_dec) + (n_load - c_load), 0);
        chk("rst_idle_tap", TAP, 0);

        // Recovery after reset.
        run(win(5, 12), 999, 0);
        chk("rec_eye_start", EYE_START, 5);
        chk("rec_eye_width", EYE_WIDTH, 8);
        chk("rec_tap", TAP, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule

// File: doc/iod_read_train_ctrl.md
# iod_read_train_ctrl

Per-lane read-training sequencer for a DDR3 PHY lane I/O block. It sweeps the lane's dynamic RX delay line one tap at a time and checks the eye monitor at each tap. It finds the longest contiguous passing window and then parks the delay line at that window's centre. It sits in the DDR3 PHY training block, on the FAB_CLK domain, and directly drives the IOD delay-line and eye-monitor controls.

## Interface
Parameters:
- TAP_MAX, 127: highest tap swept; legal range 1..254.
- SETTLE_CYCLES, 4: wait cycles after a flag clear, before sampling starts; minimum 1.
- SAMPLE_CYCLES, 8: eye-monitor observation window per tap; minimum 1.
- MIN_EYE, 4: minimum passing width for success; minimum 1.

Ports:
- FAB_CLK  in  1  single clock; all logic is rising-edge.
- ARST_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle pulse that begins training; ignored while BUSY.
- ABORT  in  1  level; terminates training.
- EYE_MONITOR_EARLY  in  1  eye-monitor early flag from the IOD.
- EYE_MONITOR_LATE  in  1  eye-monitor late flag from the IOD.
- DELAY_LINE_OUT_OF_RANGE  in  1  delay-line limit indicator from the IOD.
- DELAY_LINE_LOAD  out  1  pulse; restores the delay line to its static value, defined as tap 0.
- DELAY_LINE_MOVE  out  1  pulse; moves the delay line one tap.
- DELAY_LINE_DIRECTION  out  1  move direction: 1 = increment, 0 = decrement; valid while MOVE is high.
- EYE_MONITOR_CLEAR_FLAGS  out  1  pulse; clears the eye-monitor flags.
- BUSY  out  1  high from the cycle after START until DONE or ERROR.
- DONE  out  1  sticky; training succeeded.
- ERROR  out  1  sticky; no eye of at least MIN_EYE taps was found.
- TAP  out  8  controller's current tap count.
- EYE_START  out  8  first tap of the chosen window.
- EYE_WIDTH  out  8  width of the chosen window in taps.

## Operation
- Reset values: all outputs 0; state IDLE.
- States and transitions:
  - IDLE -> LOAD on START.
  - LOAD: pulse DELAY_LINE_LOAD; TAP = 0; run_len, best_len and best_start = 0; DONE and ERROR cleared.
  - CLEAR: pulse EYE_MONITOR_CLEAR_FLAGS.
  - SETTLE: count SETTLE_CYCLES cycles.
  - SAMPLE: for SAMPLE_CYCLES cycles, fail |= EARLY | LATE.
  - EVAL: fail additionally includes OUT_OF_RANGE.
    - Pass: if run_len == 0 then run_start = TAP; run_len++.
    - Fail: close the run (run_len > best_len updates best), then run_len = 0.
    - If TAP == TAP_MAX or OUT_OF_RANGE -> FINISH; else -> STEP.
  - STEP: DELAY_LINE_MOVE = 1 with DIRECTION = 1; TAP++; -> CLEAR.
  - FINISH: close any open run.
    - If best_len < MIN_EYE: ERROR = 1, EYE_WIDTH = best_len, -> RELOAD.
    - Else: EYE_START = best_start, EYE_WIDTH = best_len, centre = best_start + (best_len >> 1), -> RETURN.
  - RETURN: while TAP != centre, a 2-cycle loop: MOVE = 1 with DIRECTION = 0 and TAP-- in the first cycle, MOVE = 0 in the second. When TAP == centre -> DONE state: DONE = 1, -> IDLE.
  - RELOAD: pulse DELAY_LINE_LOAD; TAP = 0; -> IDLE.
- Window selection: only strictly longer windows replace the best, so on a tie the earliest window wins.
- ABORT in any non-IDLE state -> RELOAD on the next cycle; DONE and ERROR stay 0.
- Width rules: the 8-bit tap counter never wraps because TAP_MAX ≤ 254. run_len and best_len are 8-bit and saturate-free. Centre uses floor division.

## Timing
- START at cycle 0 -> LOAD at cycle 1.
- Per-tap cost: 1 (CLEAR) + SETTLE_CYCLES + SAMPLE_CYCLES + 1 (EVAL) + 1 (STEP). Defaults give 15 cycles; the last tap has no STEP.
- FINISH takes 1 cycle.
- RETURN takes 2 × (TAP_final − centre) cycles.
- DONE rises one cycle after TAP reaches centre; BUSY falls in the same cycle.
- Output pulse shape: DELAY_LINE_LOAD, DELAY_LINE_MOVE and EYE_MONITOR_CLEAR_FLAGS are exactly 1 cycle wide and registered. No two are ever high in the same cycle.
- Delay-line pulse spacing: consecutive MOVE pulses are separated by at least 1 low cycle.
- OUT_OF_RANGE is sampled in EVAL only.
- ABORT has priority over START and over every transition.
- ARST_N asserted mid-operation returns the block to its reset values immediately. No delay-line pulse is issued afterward until the next START.

## Test plan
- Eye model flags at TAP < 20 or TAP > 59, defaults, START -> EYE_START = 20, EYE_WIDTH = 40, final TAP = 40, DONE = 1. Total sweep count: 128 CLEAR pulses and 127 increment MOVEs, followed by 87 decrement MOVEs.
- Flags asserted at all taps -> ERROR = 1, EYE_WIDTH = 0, one final DELAY_LINE_LOAD, TAP = 0, DONE = 0.
- Passing windows at 10..19 and 40..49 -> EYE_START = 10, EYE_WIDTH = 10, TAP = 15 (tie goes to the earliest).
- Window at 100..127, still open at sweep end -> EYE_START = 100, EYE_WIDTH = 28, TAP = 114.
- OUT_OF_RANGE raised at tap 64 with the window at 30..63 -> sweep stops after tap 64's EVAL; EYE_WIDTH = 34, TAP = 47, DONE = 1.
- ABORT at tap 50 -> LOAD pulse on the next cycle, then IDLE; TAP = 0, BUSY = 0, DONE = ERROR = 0.
- ARST_N pulsed mid-SAMPLE -> all outputs 0 immediately; no pulses until a new START.
